rf_ext_dm_480: RTL and testbench



---
 rtl/rv_core_pkg.sv | 35 +++
 rtl/rf_ext_dm_480_if.sv | 15 +
 rtl/imm_ext_480.sv | 28 ++
 rtl/rf_ext_dm_480.sv | 126 ++++++++++++
 tb/tb_rf_ext_dm_480.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/rv_core_pkg.sv
// Shared definitions for the RV32I storage / immediate slice.
//   - DMType access codes (dm_type_e)
//   - EXTOp one-hot bit indices
//   - register-file and data-memory geometry
//   - dm_nbytes(): number of bytes touched by a given DMType
package rv_core_pkg;

  localparam int unsigned RF_DEPTH = 32;
  localparam int unsigned DM_BYTES = 128;

  typedef enum logic [2:0] {
    DM_WORD  = 3'b000,
    DM_HALF  = 3'b001,
    DM_HALFU = 3'b010,
    DM_BYTE  = 3'b011,
    DM_BYTEU = 3'b100
  } dm_type_e;

  localparam int unsigned EXT_SHAMT = 5;
  localparam int unsigned EXT_I     = 4;
  localparam int unsigned EXT_S     = 3;
  localparam int unsigned EXT_B     = 2;
  localparam int unsigned EXT_U     = 1;
  localparam int unsigned EXT_J     = 0;

  // Unused codes 101..111 behave as word accesses.
  function automatic int unsigned dm_nbytes(input logic [2:0] dm_type);
    case (dm_type)
      DM_HALF, DM_HALFU: return 2;
      DM_BYTE, DM_BYTEU: return 1;
      default:           return 4;
    endcase
  endfunction

endpackage

// File: rtl/rf_ext_dm_480_if.sv
// Data-memory access bus between the core datapath and the data memory.
//   DMWr   : write enable          addr : byte address (wraps mod 128)
//   din    : store data            DMType : access type (rv_core_pkg codes)
//   dout   : load data (combinational)
// Modports: master = datapath side, slave = memory side.
interface rf_ext_dm_480_if;
  logic        DMWr;
  logic [6:0]  addr;
  logic [31:0] din;
  logic [2:0]  DMType;
  logic [31:0] dout;

  modport master (output DMWr, addr, din, DMType, input  dout);
  modport slave  (input  DMWr, addr, din, DMType, output dout);
endinterface

// File: rtl/imm_ext_480.sv
// Combinational RV32I immediate extender.
//   iimm/simm/bimm : 12-bit I/S/B fields    uimm/jimm : 20-bit U/J fields
//   iimm_shamt     : 5-bit shift amount     EXTOp     : one-hot select
//   immout         : 32-bit immediate; highest set EXTOp bit wins, 0 if none
module imm_ext_480
  import rv_core_pkg::*;
(
  input  logic [11:0] iimm,
  input  logic [11:0] simm,
  input  logic [11:0] bimm,
  input  logic [19:0] uimm,
  input  logic [19:0] jimm,
  input  logic [4:0]  iimm_shamt,
  input  logic [5:0]  EXTOp,
  output logic [31:0] immout
);

  always_comb begin
    immout = '0;
    if (EXTOp[EXT_SHAMT])  immout = {27'b0, iimm_shamt};
    else if (EXTOp[EXT_I]) immout = {{20{iimm[11]}}, iimm};
    else if (EXTOp[EXT_S]) immout = {{20{simm[11]}}, simm};
    else if (EXTOp[EXT_B]) immout = {{19{bimm[11]}}, bimm, 1'b0};
    else if (EXTOp[EXT_U]) immout = {uimm, 12'b0};
    else if (EXTOp[EXT_J]) immout = {{11{jimm[19]}}, jimm, 1'b0};
  end

endmodule

// File: rtl/rf_ext_dm_480.sv
// Storage and immediate-generation slice of the single-cycle RV32I core.
//   clk, rstn      : CPU clock, asynchronous active-low reset (clears RF and DM)
//   sw_i           : board switches; sw_i[1] freezes all writes when the
//                    DBG_FREEZE_EN macro is defined, otherwise ignored
//   RFWr/A1/A2/A3/WD, RD1/RD2 : 32x32 register file, x0 reads zero
//   iimm..EXTOp, immout       : immediate extender (imm_ext_480)
//   dm             : data-memory bus (rf_ext_dm_480_if.slave), 128 bytes LE
//   dbg_reg_*/dbg_mem_*       : debug read ports for the display logic
module rf_ext_dm_480
  import rv_core_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic [15:0] sw_i,
  input  logic        RFWr,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [4:0]  A3,
  input  logic [31:0] WD,
  output logic [31:0] RD1,
  output logic [31:0] RD2,
  input  logic [11:0] iimm,
  input  logic [11:0] simm,
  input  logic [11:0] bimm,
  input  logic [19:0] uimm,
  input  logic [19:0] jimm,
  input  logic [4:0]  iimm_shamt,
  input  logic [5:0]  EXTOp,
  output logic [31:0] immout,
  rf_ext_dm_480_if.slave dm,
  input  logic [4:0]  dbg_reg_addr,
  output logic [31:0] dbg_reg_data,
  input  logic [6:0]  dbg_mem_addr,
  output logic [7:0]  dbg_mem_data
);

  logic frozen;
  logic unused_sw;

  assign unused_sw = ^sw_i;
`ifdef DBG_FREEZE_EN
  assign frozen = sw_i[1];
`else
  assign frozen = 1'b0;
`endif

  // ---------------- register file ----------------
  logic [31:0] rf_q [RF_DEPTH];
  logic [31:0] rf_d [RF_DEPTH];
  logic        rf_we;

  assign rf_we = RFWr && (A3 != 5'd0) && !frozen;

  always_comb begin
    rf_d = rf_q;
    if (rf_we) rf_d[A3] = WD;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < RF_DEPTH; i++) rf_q[i] <= '0;
    end else begin
      rf_q <= rf_d;
    end
  end

  assign RD1          = (A1 == 5'd0)           ? '0 : rf_q[A1];
  assign RD2          = (A2 == 5'd0)           ? '0 : rf_q[A2];
  assign dbg_reg_data = (dbg_reg_addr == 5'd0) ? '0 : rf_q[dbg_reg_addr];

  // ---------------- immediate extender ----------------
  imm_ext_480 u_imm_ext (
    .iimm       (iimm),
    .simm       (simm),
    .bimm       (bimm),
    .uimm       (uimm),
    .jimm       (jimm),
    .iimm_shamt (iimm_shamt),
    .EXTOp      (EXTOp),
    .immout     (immout)
  );

  // ---------------- data memory ----------------
  logic [7:0]  dm_q [DM_BYTES];
  logic [7:0]  dm_d [DM_BYTES];
  logic [7:0]  ld_b [4];
  int unsigned nbytes;

  assign nbytes = dm_nbytes(dm.DMType);

  // Bytewise access with 7-bit address arithmetic gives mod-128 wrap and
  // makes misaligned accesses fall out naturally.
  always_comb begin
    dm_d = dm_q;
    if (dm.DMWr && !frozen) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (i < nbytes) dm_d[dm.addr + 7'(i)] = dm.din[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < DM_BYTES; i++) dm_q[i] <= '0;
    end else begin
      dm_q <= dm_d;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) ld_b[i] = dm_q[dm.addr + 7'(i)];
  end

  always_comb begin
    case (dm.DMType)
      DM_HALF:  dm.dout = {{16{ld_b[1][7]}}, ld_b[1], ld_b[0]};
      DM_HALFU: dm.dout = {16'b0, ld_b[1], ld_b[0]};
      DM_BYTE:  dm.dout = {{24{ld_b[0][7]}}, ld_b[0]};
      DM_BYTEU: dm.dout = {24'b0, ld_b[0]};
      default:  dm.dout = {ld_b[3], ld_b[2], ld_b[1], ld_b[0]};
    endcase
  end

  assign dbg_mem_data = dm_q[dbg_mem_addr];

endmodule

// File: tb/tb_rf_ext_dm_480.sv
module tb_rf_ext_dm_480;

  logic        clk;
  logic        rstn;
  logic [15:0] sw_i;
  logic        RFWr;
  logic [4:0]  A1, A2, A3;
  logic [31:0] WD;
  logic [31:0] RD1, RD2;
  logic [11:0] iimm, simm, bimm;
  logic [19:0] uimm, jimm;
  logic [4:0]  iimm_shamt;
  logic [5:0]  EXTOp;
  logic [31:0] immout;
  logic [4:0]  dbg_reg_addr;
  logic [31:0] dbg_reg_data;
  logic [6:0]  dbg_mem_addr;
  logic [7:0]  dbg_mem_data;

  int errors = 0;
  int checks = 0;

  rf_ext_dm_480_if dm_bus ();

  rf_ext_dm_480 dut (
    .clk          (clk),
    .rstn         (rstn),
    .sw_i         (sw_i),
    .RFWr         (RFWr),
    .A1           (A1),
    .A2           (A2),
    .A3           (A3),
    .WD           (WD),
    .RD1          (RD1),
    .RD2          (RD2),
    .iimm         (iimm),
    .simm         (simm),
    .bimm         (bimm),
    .uimm         (uimm),
    .jimm         (jimm),
    .iimm_shamt   (iimm_shamt),
    .EXTOp        (EXTOp),
    .immout       (immout),
    .dm           (dm_bus),
    .dbg_reg_addr (dbg_reg_addr),
    .dbg_reg_data (dbg_reg_data),
    .dbg_mem_addr (dbg_mem_addr),
    .dbg_mem_data (dbg_mem_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0; sw_i = '0; RFWr = 1'b0; A1 = '0; A2 = '0; A3 = '0; WD = '0;
    iimm = '0; simm = '0; bimm = '0; uimm = '0; jimm = '0; iimm_shamt = '0;
    EXTOp = '0; dbg_reg_addr = '0; dbg_mem_addr = '0;
    dm_bus.DMWr = 1'b0; dm_bus.addr = '0; dm_bus.din = '0; dm_bus.DMType = 3'b000;

    // Reset state
    tick();
    A1 = 5'd5; A2 = 5'd9; dbg_reg_addr = 5'd5; dm_bus.addr = 7'd4; dbg_mem_addr = 7'd4;
    #1;
    chk("rst_rd1", RD1, 32'h0);
    chk("rst_rd2", RD2, 32'h0);
    chk("rst_dout", dm_bus.dout, 32'h0);
    chk("rst_immout", immout, 32'h0);
    chk("rst_dbgmem", {24'h0, dbg_mem_data}, 32'h0);
    rstn = 1'b1;
    #1;

    // RF write to x5: old value visible until the edge
    A3 = 5'd5; WD = 32'hDEADBEEF; RFWr = 1'b1;
    #1;
    chk("rf_pre_edge", RD1, 32'h0);
    tick();
    RFWr = 1'b0;
    #1;
    chk("rf_post_edge", RD1, 32'hDEADBEEF);
    chk("dbg_reg_x5", dbg_reg_data, 32'hDEADBEEF);

    // Write to x0 discarded
    A3 = 5'd0; WD = 32'h1234; RFWr = 1'b1; A2 = 5'd0;
    tick();
    RFWr = 1'b0;
    #1;
    chk("rf_x0", RD2, 32'h0);
    dbg_reg_addr = 5'd0;
    #1;
    chk("dbg_reg_x0", dbg_reg_data, 32'h0);

    // Immediates
    bimm = 12'hFFE; EXTOp = 6'b000100; #1;
    chk("imm_b", immout, 32'hFFFFFFFC);
    uimm = 20'h12345; EXTOp = 6'b000010; #1;
    chk("imm_u", immout, 32'h12345000);
    iimm_shamt = 5'd31; EXTOp = 6'b100000; #1;
    chk("imm_shamt", immout, 32'h0000001F);
    iimm = 12'h800; EXTOp = 6'b010000; #1;
    chk("imm_i_neg", immout, 32'hFFFFF800);
    iimm = 12'hFFF; iimm_shamt = 5'd3; EXTOp = 6'b110000; #1;
    chk("imm_prio", immout, 32'h00000003);
    simm = 12'h7FF; EXTOp = 6'b001000; #1;
    chk("imm_s_pos", immout, 32'h000007FF);
    jimm = 20'h80000; EXTOp = 6'b000001; #1;
    chk("imm_j_neg", immout, 32'hFFF00000);
    EXTOp = 6'b000000; #1;
    chk("imm_none", immout, 32'h0);

    // Store word 0x80FF7F01 at addr 4
    dm_bus.addr = 7'd4; dm_bus.din = 32'h80FF7F01; dm_bus.DMType = 3'b000; dm_bus.DMWr = 1'b1;
    tick();
    dm_bus.DMWr = 1'b0;
    #1;
    chk("ld_word4", dm_bus.dout, 32'h80FF7F01);
    dm_bus.addr = 7'd5; dm_bus.DMType = 3'b011; #1;
    chk("ld_b_5", dm_bus.dout, 32'h0000007F);
    dm_bus.addr = 7'd6; dm_bus.DMType = 3'b011; #1;
    chk("ld_b_6", dm_bus.dout, 32'hFFFFFFFF);
    dm_bus.DMType = 3'b100; #1;
    chk("ld_bu_6", dm_bus.dout, 32'h000000FF);
    dm_bus.DMType = 3'b001; #1;
    chk("ld_h_6", dm_bus.dout, 32'hFFFF80FF);
    dm_bus.DMType = 3'b010; #1;
    chk("ld_hu_6", dm_bus.dout, 32'h000080FF);
    dm_bus.addr = 7'd4; dm_bus.DMType = 3'b111; #1;
    chk("ld_code7_word", dm_bus.dout, 32'h80FF7F01);

    // Byte store at 127, wrap on word load
    dm_bus.addr = 7'd127; dm_bus.din = 32'h123456AA; dm_bus.DMType = 3'b011; dm_bus.DMWr = 1'b1;
    tick();
    dm_bus.DMWr = 1'b0; dm_bus.DMType = 3'b000; dbg_mem_addr = 7'd127;
    #1;
    chk("ld_wrap_word", dm_bus.dout, 32'h000000AA);
    chk("dbg_mem_127", {24'h0, dbg_mem_data}, 32'h000000AA);

    // Half store wrapping across 127 -> 0
    dm_bus.din = 32'h5555BEEF; dm_bus.DMType = 3'b001; dm_bus.DMWr = 1'b1;
    tick();
    dm_bus.DMWr = 1'b0; dm_bus.DMType = 3'b010; dbg_mem_addr = 7'd0;
    #1;
    chk("ld_wrap_half", dm_bus.dout, 32'h0000BEEF);
    chk("dbg_mem_0", {24'h0, dbg_mem_data}, 32'h000000BE);
    dbg_mem_addr = 7'd1; #1;
    chk("dbg_mem_1", {24'h0, dbg_mem_data}, 32'h0);

    // Freeze switch
    sw_i = 16'h0002; A1 = 5'd7; A3 = 5'd7; WD = 32'h55; RFWr = 1'b1;
    dm_bus.addr = 7'd10; dm_bus.din = 32'h11; dm_bus.DMType = 3'b100; dm_bus.DMWr = 1'b1;
    dbg_mem_addr = 7'd10;
    tick();
`ifdef DBG_FREEZE_EN
    chk("frz_rf", RD1, 32'h0);
    chk("frz_dm", {24'h0, dbg_mem_data}, 32'h0);
    sw_i = '0;
    tick();
`endif
    RFWr = 1'b0; dm_bus.DMWr = 1'b0;
    #1;
    chk("unfrz_rf", RD1, 32'h55);
    chk("unfrz_dm", {24'h0, dbg_mem_data}, 32'h11);
    sw_i = '0;

    // Asynchronous reset mid-run, with a write pending
    A1 = 5'd5; A2 = 5'd7; dm_bus.addr = 7'd4; dm_bus.DMType = 3'b000;
    dbg_reg_addr = 5'd5; dbg_mem_addr = 7'd127;
    A3 = 5'd9; WD = 32'hCAFEF00D; RFWr = 1'b1;
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_rd1", RD1, 32'h0);
    chk("arst_rd2", RD2, 32'h0);
    chk("arst_dout", dm_bus.dout, 32'h0);
    chk("arst_dbgreg", dbg_reg_data, 32'h0);
    chk("arst_dbgmem", {24'h0, dbg_mem_data}, 32'h0);
    tick();
    A2 = 5'd9; #1;
    chk("arst_pending", RD2, 32'h0);
    RFWr = 1'b0;
    rstn = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
